// File: rtl/mux_arb_2.sv
// Two-requester arbitrated 8-bit 2:1 mux with a registered output beat and fair alternation.
// Optional grant locking with a HOLD_MAX beat limit is enabled by defining MUX_ARB_LOCK_EN.
module mux_arb_2 #(
    parameter int HOLD_MAX = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] x_data,
    input  logic       x_valid,
    output logic       x_ready,
    input  logic       x_lock,
    input  logic [7:0] y_data,
    input  logic       y_valid,
    output logic       y_ready,
    input  logic       y_lock,
    output logic [7:0] m_data,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       sel
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_X = 2'd1,
        GNT_Y = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_last_y;
    logic       r_m_valid;
    logic [7:0] r_m_data;
    logic       w_space;
    logic       w_acc_x;
    logic       w_acc_y;
    logic       w_acc;
    logic       w_lock_cont;
    logic [7:0] w_sel_data;

    assign w_space    = !r_m_valid || m_ready;
    assign x_ready    = (r_state == GNT_X) && w_space;
    assign y_ready    = (r_state == GNT_Y) && w_space;
    assign w_acc_x    = x_valid && x_ready;
    assign w_acc_y    = y_valid && y_ready;
    assign w_acc      = w_acc_x || w_acc_y;
    assign sel        = (r_state == GNT_Y);
    assign w_sel_data = sel ? y_data : x_data;
    assign m_data     = r_m_data;
    assign m_valid    = r_m_valid;

`ifdef MUX_ARB_LOCK_EN
    localparam logic [4:0] HOLD_LIM = 5'(HOLD_MAX);

    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [4:0] w_cnt_inc;
    logic       w_hold_done;
    logic       w_lock_req;
    logic       w_other_valid;

    assign w_cnt_inc     = {1'b0, r_cnt} + 5'd1;
    assign w_hold_done   = (w_cnt_inc >= HOLD_LIM);
    assign w_lock_req    = (r_state == GNT_Y) ? y_lock : x_lock;
    assign w_other_valid = (r_state == GNT_Y) ? x_valid : y_valid;
    // Once the hold limit is reached the lock only yields if the other side is waiting.
    assign w_lock_cont   = w_acc && w_lock_req && (!w_hold_done || !w_other_valid);

    // Beat counter: saturating count of accepts within one grant.
    always_comb begin
        w_cnt_nxt = r_cnt;
        if ((w_state_nxt != r_state) || (w_state_nxt == IDLE)) begin
            w_cnt_nxt = 4'd0;
        end else if (w_acc && ({1'b0, r_cnt} < HOLD_LIM)) begin
            w_cnt_nxt = w_cnt_inc[3:0];
        end else begin
            w_cnt_nxt = r_cnt;
        end
    end

    // Beat counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else begin
            r_cnt <= w_cnt_nxt;
        end
    end
`else
    logic w_unused_lock;

    assign w_unused_lock = x_lock ^ y_lock;
    assign w_lock_cont   = 1'b0;
`endif

    // Arbitration next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (x_valid && y_valid) begin
                    w_state_nxt = r_last_y ? GNT_X : GNT_Y;
                end else if (x_valid) begin
                    w_state_nxt = GNT_X;
                end else if (y_valid) begin
                    w_state_nxt = GNT_Y;
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            GNT_X: begin
                if (w_acc) begin
                    if (w_lock_cont) begin
                        w_state_nxt = GNT_X;
                    end else if (y_valid) begin
                        w_state_nxt = GNT_Y;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (!x_valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GNT_X;
                end
            end
            GNT_Y: begin
                if (w_acc) begin
                    if (w_lock_cont) begin
                        w_state_nxt = GNT_Y;
                    end else if (x_valid) begin
                        w_state_nxt = GNT_X;
                    end else begin
                        w_state_nxt = IDLE;
                    end
                end else if (!y_valid) begin
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = GNT_Y;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Arbitration state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Output beat register and record of the last served requester.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= 8'h00;
            r_last_y  <= 1'b1;
        end else if (w_acc) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_sel_data;
            r_last_y  <= w_acc_y;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
        end else begin
            r_m_valid <= r_m_valid;
        end
    end

endmodule
